// File: rtl/layer_requant_packer.sv
// layer_requant_packer: takes one sign-magnitude MAC result per handshake,
// adds the neuron bias, applies optional ReLU, requantizes to an 8-bit
// sign-magnitude activation, and packs it into lane fill_count of a wide
// vector. A complete frame is held on out_vec until the consumer takes it.
module layer_requant_packer #(
    parameter int N_OUT = 30,
    parameter int IN_W  = 21,
    parameter int SHIFT = 7,
    parameter bit RELU  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_W-1:0]            in_data,
    input  logic [7:0]                 in_bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8*N_OUT-1:0]         out_vec,
    output logic [$clog2(N_OUT+1)-1:0] fill_count,
    output logic                       frame_sat
);

    localparam int CNT_W = $clog2(N_OUT+1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Sign-magnitude MAC result -> two's complement after the magnitude shift.
    // Negative zero collapses to zero because -0 == 0.
    function automatic logic signed [IN_W:0] mac_to_signed(input logic [IN_W-1:0] d);
        logic [IN_W-2:0]      mag;
        logic signed [IN_W:0] x;
        mag = d[IN_W-2:0] >> SHIFT;
        x   = signed'({2'b00, mag});
        return d[IN_W-1] ? -x : x;
    endfunction

    // Sign-magnitude bias byte -> two's complement at the accumulator width.
    function automatic logic signed [IN_W:0] bias_to_signed(input logic [7:0] b);
        logic signed [IN_W:0] x;
        x = signed'({{(IN_W-6){1'b0}}, b[6:0]});
        return b[7] ? -x : x;
    endfunction

    // Returns {saturated, lane_byte}. ReLU clamping is not reported as saturation,
    // and a zero result is always encoded as 0x00, never as negative zero.
    function automatic logic [8:0] requant_sat(input logic signed [IN_W:0] v);
        logic signed [IN_W:0] mag;
        logic                 neg;
        neg = v[IN_W];
        mag = neg ? -v : v;
        if (RELU) begin
            if (neg || (v == '0))            return 9'h000;
            else if (mag > (IN_W+1)'(127))   return {1'b1, 8'h7F};
            else                             return {2'b00, mag[6:0]};
        end else begin
            if (v == '0)                     return 9'h000;
            else if (mag > (IN_W+1)'(127))   return {1'b1, neg, 7'h7F};
            else                             return {1'b0, neg, mag[6:0]};
        end
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     fill_q, fill_d;
    logic                 sat_q, sat_d;
    logic [8*N_OUT-1:0]   vec_q, vec_d;
    logic signed [IN_W:0] sum_v;
    logic [8:0]           lane_res;

    // Bias add cannot overflow: one guard bit above the MAC width covers it.
    assign sum_v    = mac_to_signed(in_data) + bias_to_signed(in_bias);
    assign lane_res = requant_sat(sum_v);

    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == FULL);
    assign out_vec    = vec_q;
    assign fill_count = fill_q;
    assign frame_sat  = sat_q;

    // Next-state: write lanes in order while collecting, hold the frame while full.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        sat_d   = sat_q;
        vec_d   = vec_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    for (int i = 0; i < N_OUT; i++) begin
                        if (fill_q == CNT_W'(i)) begin
                            vec_d[8*i +: 8] = lane_res[7:0];
                        end
                    end
                    fill_d = fill_q + CNT_W'(1);
                    sat_d  = sat_q | lane_res[8];
                    if (fill_q == CNT_W'(N_OUT-1)) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                // Old lane contents stay in place; the next frame overwrites them.
                if (out_ready) begin
                    state_d = COLLECT;
                    fill_d  = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // State registers with synchronous active-low reset that drops any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            fill_q  <= '0;
            sat_q   <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            sat_q   <= sat_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_layer_requant_packer.sv
// Testbench for layer_requant_packer: two instances (SHIFT=7/ReLU and
// SHIFT=0/signed) share the same stimulus; a frame-level reference model feeds
// expected frames into queues that a monitor pops when out_valid rises.
module tb_layer_requant_packer;

    localparam int N  = 30;
    localparam int IW = 21;
    localparam int CW = $clog2(N+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic [7:0]    in_bias = '0;

    logic          a_ready, b_ready, a_valid, b_valid, a_sat, b_sat;
    logic [8*N-1:0] a_vec, b_vec;
    logic [CW-1:0]  a_fill, b_fill;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    layer_requant_packer #(.N_OUT(N), .IN_W(IW), .SHIFT(7), .RELU(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .in_bias(in_bias), .out_valid(a_valid),
        .out_ready(out_ready), .out_vec(a_vec), .fill_count(a_fill),
        .frame_sat(a_sat)
    );

    layer_requant_packer #(.N_OUT(N), .IN_W(IW), .SHIFT(0), .RELU(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready),
        .in_data(in_data), .in_bias(in_bias), .out_valid(b_valid),
        .out_ready(out_ready), .out_vec(b_vec), .fill_count(b_fill),
        .frame_sat(b_sat)
    );

    typedef struct packed {
        logic [8*N-1:0] vec;
        logic           sat;
    } frame_t;

    frame_t qa[$];
    frame_t qb[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference quantizer in plain integer arithmetic: returns {sat, byte}.
    function automatic logic [8:0] ref_q(input logic [IW-1:0] d, input logic [7:0] b,
                                         input int sh, input bit relu);
        int v, a;
        v = int'(d[IW-2:0]) >> sh;
        if (d[IW-1]) v = -v;
        v = v + (b[7] ? -int'(b[6:0]) : int'(b[6:0]));
        a = (v < 0) ? -v : v;
        if (relu) begin
            if (v <= 0)  return 9'h000;
            if (v > 127) return 9'h17F;
            return {1'b0, 8'(v)};
        end
        if (v == 0)  return 9'h000;
        if (a > 127) return {1'b1, (v < 0), 7'h7F};
        return {1'b0, (v < 0), 7'(a)};
    endfunction

    function automatic logic [IW-1:0] sm(input bit s, input int m);
        return {s, 20'(m)};
    endfunction

    function automatic logic [7:0] lane(input logic [8*N-1:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    function automatic logic [IW-1:0] rnd_data();
        int         w;
        logic [19:0] m;
        w = $urandom_range(1, 20);
        m = 20'($urandom) & 20'((1 << w) - 1);
        return {1'($urandom), m};
    endfunction

    // Reference model: frame buffer, lane count and full flag per the handshake rules.
    logic [8*N-1:0] ma_vec, mb_vec;
    logic           ma_sat, mb_sat;
    int             m_fill = 0;
    bit             m_full = 1'b0;
    bit             started = 1'b0;

    always @(posedge clk) begin
        logic [8:0] ra, rb;
        if (!rst_n) begin
            ma_vec = '0; mb_vec = '0; ma_sat = 1'b0; mb_sat = 1'b0;
            m_fill = 0; m_full = 1'b0;
            qa.delete(); qb.delete();
            started = 1'b1;
        end else if (!m_full) begin
            if (in_valid) begin
                ra = ref_q(in_data, in_bias, 7, 1'b1);
                rb = ref_q(in_data, in_bias, 0, 1'b0);
                ma_vec[8*m_fill +: 8] = ra[7:0];
                mb_vec[8*m_fill +: 8] = rb[7:0];
                ma_sat = ma_sat | ra[8];
                mb_sat = mb_sat | rb[8];
                m_fill++;
                if (m_fill == N) begin
                    m_full = 1'b1;
                    qa.push_back({ma_vec, ma_sat});
                    qb.push_back({mb_vec, mb_sat});
                end
            end
        end else if (out_ready) begin
            m_full = 1'b0; m_fill = 0; ma_sat = 1'b0; mb_sat = 1'b0;
        end
    end

    // Monitor: per-cycle control checks, frame pop on out_valid rise, hold check while full.
    frame_t ea, eb;
    bit     prev_v = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            chk("a_fill", a_fill, m_fill);
            chk("b_fill", b_fill, m_fill);
            chk("a_out_valid", a_valid, m_full);
            chk("b_out_valid", b_valid, m_full);
            chk("a_in_ready", a_ready, !m_full);
            chk("b_in_ready", b_ready, !m_full);
            if (a_valid && !prev_v) begin
                n_tests++;
                if (qa.size() == 0 || qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_pop: got out_valid=1 expected no frame pending");
                end else begin
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                end
            end
            if (a_valid) begin
                chk("a_frame_vec", a_vec, ea.vec);
                chk("a_frame_sat", a_sat, ea.sat);
                chk("b_frame_vec", b_vec, eb.vec);
                chk("b_frame_sat", b_sat, eb.sat);
            end
            prev_v = a_valid;
        end
    end

    task automatic push(input logic [IW-1:0] d, input logic [7:0] b);
        int guard = 0;
        while (!a_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!a_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
        in_valid = 1'b1;
        in_data  = d;
        in_bias  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*N-1:0] exp_vec;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_vec", a_vec, '0);
        chk("rst_sat", a_sat, 1'b0);
        chk("rst_fill", a_fill, 0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_ready", a_ready, 1'b1);

        // Basic lane write: 1000>>7 = 7, plus 3.
        push(sm(0, 1000), 8'h03);
        chk("t1_a_lane0", lane(a_vec, 0), 8'h0A);
        chk("t1_fill", a_fill, 1);
        chk("t1_a_sat", a_sat, 1'b0);
        chk("t1_b_lane0", lane(b_vec, 0), 8'h7F);

        // Negative results and negative zero.
        push(sm(1, 73), 8'h00);
        chk("t2_a_lane1", lane(a_vec, 1), 8'h00);
        chk("t2_b_lane1", lane(b_vec, 1), 8'hC9);
        push(sm(1, 0), 8'h80);
        chk("t2_a_lane2", lane(a_vec, 2), 8'h00);
        chk("t2_b_lane2", lane(b_vec, 2), 8'h00);

        // Saturation, positive and negative.
        push(sm(0, 20'hFFFFF), 8'h00);
        chk("t3_a_lane3", lane(a_vec, 3), 8'h7F);
        push(sm(1, 20'hFFFFF), 8'h00);
        chk("t3_a_lane4", lane(a_vec, 4), 8'h00);
        chk("t3_b_lane4", lane(b_vec, 4), 8'hFF);
        for (int i = 5; i < N; i++) push(sm(0, i << 7), 8'h00);
        chk("t3_valid", a_valid, 1'b1);
        chk("t3_a_sat", a_sat, 1'b1);
        chk("t3_b_sat", b_sat, 1'b1);
        handoff();

        // Full frame with lane i = i, held under backpressure.
        for (int i = 0; i < N; i++) push(sm(0, i << 7), 8'h00);
        chk("t4_valid", a_valid, 1'b1);
        chk("t4_in_ready", a_ready, 1'b0);
        chk("t4_sat", a_sat, 1'b0);
        for (int i = 0; i < N; i++) exp_vec[8*i +: 8] = 8'(i);
        repeat (5) begin
            chk("t4_hold_vec", a_vec, exp_vec);
            @(negedge clk);
        end

        // Input offered while full is ignored.
        in_valid = 1'b1;
        repeat (4) begin
            in_data = rnd_data();
            in_bias = 8'($urandom);
            @(negedge clk);
            chk("t6_ign_vec", a_vec, exp_vec);
            chk("t6_ign_fill", a_fill, N);
        end
        in_valid = 1'b0;
        handoff();
        chk("t4_after_valid", a_valid, 1'b0);
        chk("t4_after_ready", a_ready, 1'b1);
        chk("t4_after_fill", a_fill, 0);

        // out_ready while collecting has no effect.
        for (int i = 0; i < 5; i++) push(rnd_data(), 8'($urandom));
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        chk("t6_col_fill", a_fill, 5);
        chk("t6_col_valid", a_valid, 1'b0);

        // Reset mid-frame after 12 accepts.
        for (int i = 0; i < 7; i++) push(rnd_data(), 8'($urandom));
        chk("t5_pre_fill", a_fill, 12);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_fill", a_fill, 0);
        chk("t5_valid", a_valid, 1'b0);
        chk("t5_sat", a_sat, 1'b0);
        chk("t5_ready", a_ready, 1'b1);
        push(sm(0, 9 << 7), 8'h81);
        chk("t5_lane0", lane(a_vec, 0), 8'h08);
        chk("t5_fill1", a_fill, 1);

        // Randomized traffic with random backpressure.
        repeat (1500) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = rnd_data();
            in_bias   = 8'($urandom);
            out_ready = ($urandom % 3) == 0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
